// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit for the EX stage.
//
// Accepts a Start request, holds Busy for a fixed op-dependent latency, then
// commits the 64-bit product or quotient/remainder into HI/LO. mthi/mtlo
// write HI/LO directly with zero stall.
//
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (codes
// 7-10). Without it those codes are treated as undefined (no effect).
//
// Parameters:
//   MULT_CYCLES  Busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES   Busy cycles for divide ops (>= 1)
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous active-high reset, clears all state
//   Start  in   1   qualifies MDUOp
//   MDUOp  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                   7 madd, 8 maddu, 9 msub, 10 msubu
//   A      in   32  rs operand
//   B      in   32  rt operand
//   Busy   out  1   operation in flight (registered)
//   HI     out  32  architectural HI
//   LO     out  32  architectural LO
// -----------------------------------------------------------------------------
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    mdu_op_e          op_q;

    // Launch decode for the incoming request
    logic             launch;
    logic [CNT_W-1:0] launch_cnt;

    always_comb begin
        launch     = 1'b0;
        launch_cnt = '0;
        case (MDUOp)
            OP_MULT, OP_MULTU: begin
                launch     = 1'b1;
                launch_cnt = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
                launch     = 1'b1;
                launch_cnt = DIV_LOAD;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                launch     = 1'b1;
                launch_cnt = MULT_LOAD;
            end
`endif
            default: ;
        endcase
    end

    // Result datapath, driven only by the latched operands
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [63:0] res;
    logic        res_we;

    always_comb begin
        // Sign-extending to 64 bits makes the low 64 bits of the unsigned
        // product equal the two's-complement signed product.
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'b0, a_q} * {32'b0, b_q};

        // Signed divide via magnitudes: avoids the -2^31 / -1 overflow and
        // yields truncation toward zero with remainder following the dividend.
        a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        quot_s = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s  = a_q[31] ? (~r_mag + 32'd1) : r_mag;
        quot_u = a_q / b_q;
        rem_u  = a_q % b_q;

        res    = '0;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                res    = prod_s;
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res    = prod_u;
                res_we = 1'b1;
            end
            OP_DIV: begin
                res    = {rem_s, quot_s};
                res_we = (b_q != '0);
            end
            OP_DIVU: begin
                res    = {rem_u, quot_u};
                res_we = (b_q != '0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res    = {HI, LO} + prod_s;
                res_we = 1'b1;
            end
            OP_MADDU: begin
                res    = {HI, LO} + prod_u;
                res_we = 1'b1;
            end
            OP_MSUB: begin
                res    = {HI, LO} - prod_s;
                res_we = 1'b1;
            end
            OP_MSUBU: begin
                res    = {HI, LO} - prod_u;
                res_we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (launch) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= mdu_op_e'(MDUOp);
                            cnt   <= launch_cnt;
                            Busy  <= 1'b1;
                            state <= RUN;
                        end else if (MDUOp == OP_MTHI) begin
                            HI <= A;
                        end else if (MDUOp == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    // Start is deliberately not examined here
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (res_we) begin
                            HI <= res[63:32];
                            LO <= res[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu: directed scenarios followed by
// randomized operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    mdu #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDUOp(MDUOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: applies op to ref_hi/ref_lo, returns expected latency.
    function automatic int unsigned model(input int unsigned op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     acc, p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        acc = {ref_hi, ref_lo};
        case (op)
            1: begin p = sa * sb; {ref_hi, ref_lo} = p; return MULT_CYCLES; end
            2: begin p = ua * ub; {ref_hi, ref_lo} = p; return MULT_CYCLES; end
            3: begin
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    q = sq; r = sr;
                    ref_lo = q[31:0]; ref_hi = r[31:0];
                end
                return DIV_CYCLES;
            end
            4: begin
                if (b != 0) begin
                    q = ua / ub; r = ua % ub;
                    ref_lo = q[31:0]; ref_hi = r[31:0];
                end
                return DIV_CYCLES;
            end
            5: begin ref_hi = a; return 0; end
            6: begin ref_lo = a; return 0; end
`ifdef MDU_MADD_EN
            7:  begin p = acc + 64'(sa * sb); {ref_hi, ref_lo} = p; return MULT_CYCLES; end
            8:  begin p = acc + ua * ub;      {ref_hi, ref_lo} = p; return MULT_CYCLES; end
            9:  begin p = acc - 64'(sa * sb); {ref_hi, ref_lo} = p; return MULT_CYCLES; end
            10: begin p = acc - ua * ub;      {ref_hi, ref_lo} = p; return MULT_CYCLES; end
`endif
            default: return 0;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    // noise: scramble A/B every cycle and issue stray Starts while running.
    task automatic run_op(input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        int unsigned lat;
        logic [31:0] old_hi, old_lo;
        old_hi = ref_hi;
        old_lo = ref_lo;
        lat    = model(op, a, b);
        Start  = 1'b1;
        MDUOp  = op[3:0];
        A      = a;
        B      = b;
        @(negedge clk);
        Start = 1'b0;
        for (int unsigned k = 1; k <= lat; k++) begin
            check("busy_run", Busy, 1);
            check("hi_hold", HI, old_hi);
            check("lo_hold", LO, old_lo);
            if (noise) begin
                A = $urandom;
                B = $urandom;
                if (k == 1) begin
                    Start = 1'b1;
                    MDUOp = 4'd5;
                    A     = 32'h1234;
                end else if (k < lat) begin
                    Start = 1'($urandom_range(0, 1));
                    MDUOp = 4'($urandom_range(1, 6));
                end else begin
                    Start = 1'b0;
                end
            end
            @(negedge clk);
        end
        Start = 1'b0;
        check("busy_done", Busy, 0);
        check("hi_result", HI, ref_hi);
        check("lo_result", LO, ref_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = '0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", Busy, 0);
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);

        // mult / multu of -2 x 3
        run_op(1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        run_op(2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        // div -7 / 2
        run_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // divu by zero leaves preloaded HI/LO
        run_op(5, 32'h11, 32'd0, 1'b0);
        run_op(6, 32'h22, 32'd0, 1'b0);
        run_op(4, 32'd7, 32'd0, 1'b0);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        // overflow divide with mthi pulsed mid-run
        run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'h0);

        // mtlo, then mult with A/B churning
        run_op(6, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mtlo_lo", LO, 32'hDEAD_BEEF);
        run_op(1, 32'h1234_5678, 32'h8765_4321, 1'b1);

        // reset in the middle of a div
        Start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_hi = '0;
        ref_lo = '0;
        check("rst_busy", Busy, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi", HI, 32'hFFFF_FFFE);
        check("multu_max_lo", LO, 32'h0000_0001);

        // accumulate ops (undefined codes when the feature is off)
        run_op(5, 32'h0, 32'd0, 1'b0);
        run_op(6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(7, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        check("madd_hi", HI, 32'h1);
        check("madd_lo", LO, 32'h0);
`else
        check("madd_off_hi", HI, 32'h0);
        check("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif
        run_op(10, 32'd1, 32'd2, 1'b0);
`ifdef MDU_MADD_EN
        check("msubu_hi", HI, 32'h0);
        check("msubu_lo", LO, 32'hFFFF_FFFE);
`else
        check("msubu_off_hi", HI, 32'h0);
        check("msubu_off_lo", LO, 32'hFFFF_FFFF);
`endif

        // randomized operations, including undefined codes 11-15
        for (int i = 0; i < 300; i++) begin
            run_op($urandom_range(0, 15), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
